wdt_axi_read_slave: RTL
=======================

Name: wdt_axi_read_slave

Overview:
- AXI read-channel (AR/R) responder that gives the CPU read-back of the watchdog's control and status registers.
- It is the read-side companion of the existing write-only WDT slave wrapper and sits on the same AXI slave port of the bus interconnect.
- It samples WDT control/state signals and returns them through single or burst reads.
- It owns one sticky timeout flag that is cleared when software reads it.

Parameters:
- BASE_ADDR, 32'h1001_0000, WDT register base address.
- OFS_WDEN, 32'h100, offset of the WDEN register.
- OFS_WDLIVE, 32'h200, offset of the WDLIVE register.
- OFS_WTOCNT, 32'h300, offset of the WTOCNT register.
- OFS_CNT, 32'h400, offset of the live counter value.
- OFS_STATUS, 32'h500, offset of the status register (read-to-clear).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- ARID_S  in  8  read ID
- ARADDR_S  in  32  read address
- ARLEN_S  in  4  burst length minus 1
- ARSIZE_S  in  3  beat size; only 3'b010 is legal
- ARBURST_S  in  2  burst type; 2'b00 FIXED, 2'b01 INCR
- ARVALID_S  in  1  address valid
- ARREADY_S  out  1  address ready
- RID_S  out  8  returned ID
- RDATA_S  out  32  read data
- RRESP_S  out  2  response; 2'b00 OKAY, 2'b10 SLVERR
- RLAST_S  out  1  last beat
- RVALID_S  out  1  data valid
- RREADY_S  in  1  data ready
- wden  in  1  WDT enable, from the write wrapper
- wdlive  in  1  WDT kick, from the write wrapper
- wtocnt  in  32  programmed timeout count
- wdt_cnt  in  32  current WDT counter
- wto  in  1  live timeout pulse/level

Behaviour:
- Clock is ACLK. Reset is ARESETn, asynchronous and active-low; all flops reset on its falling edge.
- Reset values: state IDLE, ARREADY_S=1, RVALID_S=0, RLAST_S=0, RID_S=0, RDATA_S=0, RRESP_S=0, sticky flag=0, beat counter=0.
- Reset asserted mid-burst aborts the burst immediately: RVALID_S drops asynchronously and no further beats are issued.
- State IDLE:
  - ARREADY_S=1, RVALID_S=0.
  - On ARVALID_S=1 at edge N, capture ARID/ARADDR/ARLEN/ARSIZE/ARBURST, load beat 0 into the R registers and go to READ.
  - RVALID_S=1 from cycle N+1 (one-cycle AR-to-R latency).
- State READ:
  - ARREADY_S=0; any new ARVALID_S is held off.
  - RVALID_S stays 1 for the whole burst.
  - RDATA_S, RRESP_S, RLAST_S and RID_S must stay stable while RVALID_S=1 and RREADY_S=0.
  - On each RVALID_S&RREADY_S handshake that is not the last beat:
    - beat counter +1;
    - address +4 for INCR, unchanged for FIXED;
    - next beat loaded at the same edge, so back-to-back beats need no bubble.
  - On the last-beat handshake (beat counter == captured ARLEN): go to IDLE; RVALID_S=0 and ARREADY_S=1 the next cycle.
- RLAST_S=1 only on beat ARLEN; a single read (ARLEN=0) has RLAST_S=1 on its only beat.
- RID_S equals the captured ARID for every beat.
- Data is sampled from the inputs when the beat is loaded, not when it is accepted. Per-beat address decode (full 32-bit compare against BASE_ADDR+offset):
  - WDEN: data = {31'b0, wden}.
  - WDLIVE: data = {31'b0, wdlive}.
  - WTOCNT: data = wtocnt.
  - CNT: data = wdt_cnt.
  - STATUS: data = {28'b0, wdlive, wden, sticky, wto}.
  - Any other address: data 0, RRESP_S=SLVERR.
- If the captured ARSIZE != 3'b010 or ARBURST == 2'b10/2'b11, every beat returns data 0 with SLVERR; beat count and RLAST_S are unchanged.
- Sticky flag:
  - Set on any cycle with wto=1.
  - Cleared at the handshake edge of a beat whose address decodes to STATUS with OKAY.
  - If wto=1 on that same cycle, set wins and the flag stays 1.
- Address arithmetic is 32-bit modulo; wrap past 32'hFFFF_FFFC falls into unmapped space (SLVERR) and is not blocked.

Test Plan:
- Reset, then AR (ID 8'h3C, addr 32'h1001_0300, LEN 0, SIZE 3'b010) with wtocnt=32'h0000_1234 and RREADY_S=1 -> RVALID_S one cycle after AR handshake with RDATA_S=32'h1234, RID_S=8'h3C, RLAST_S=1, RRESP_S=OKAY; ARREADY_S=1 the following cycle.
- INCR burst addr 32'h1001_0100, LEN 4 -> 5 beats: WDEN, 0/SLVERR at +0x104, 0/SLVERR at +0x108, 0/SLVERR at +0x10C, 0/SLVERR at +0x110; RLAST_S only on beat 4.
  - Repeat with addr 32'h1001_0400, FIXED, LEN 3 -> 4 beats, each equal to wdt_cnt at its load time.
- Hold RREADY_S=0 for 5 cycles on beat 1 while wdt_cnt changes -> RDATA_S and RLAST_S stable throughout; burst resumes on RREADY_S=1.
- Pulse wto for 1 cycle, then read STATUS -> RDATA_S[1]=1; second STATUS read -> bit1=0.
  - Repeat with wto=1 on the clear-handshake cycle -> bit1 still reads 1 afterwards.
- ARSIZE_S=3'b001, LEN 1 -> 2 beats, both 0/SLVERR, RLAST_S on beat 1.
  - ARBURST_S=2'b10 -> SLVERR on all beats.
- Deassert ARESETn during beat 2 of a LEN 7 burst -> RVALID_S=0 immediately, ARREADY_S=1 once released, next single read returns correct data.

Source files
------------

// File: rtl/wdt_axi_read_slave.sv
// AXI AR/R responder that returns the watchdog control and status registers.
// It also owns the sticky timeout flag, which is cleared when software reads STATUS.
module wdt_axi_read_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter logic [31:0] OFS_WDEN   = 32'h100,
    parameter logic [31:0] OFS_WDLIVE = 32'h200,
    parameter logic [31:0] OFS_WTOCNT = 32'h300,
    parameter logic [31:0] OFS_CNT    = 32'h400,
    parameter logic [31:0] OFS_STATUS = 32'h500
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [7:0]  ARID_S,
    input  logic [31:0] ARADDR_S,
    input  logic [3:0]  ARLEN_S,
    input  logic [2:0]  ARSIZE_S,
    input  logic [1:0]  ARBURST_S,
    input  logic        ARVALID_S,
    output logic        ARREADY_S,
    output logic [7:0]  RID_S,
    output logic [31:0] RDATA_S,
    output logic [1:0]  RRESP_S,
    output logic        RLAST_S,
    output logic        RVALID_S,
    input  logic        RREADY_S,
    input  logic        wden,
    input  logic        wdlive,
    input  logic [31:0] wtocnt,
    input  logic [31:0] wdt_cnt,
    input  logic        wto
);

    localparam logic [31:0] ADDR_WDEN   = BASE_ADDR + OFS_WDEN;
    localparam logic [31:0] ADDR_WDLIVE = BASE_ADDR + OFS_WDLIVE;
    localparam logic [31:0] ADDR_WTOCNT = BASE_ADDR + OFS_WTOCNT;
    localparam logic [31:0] ADDR_CNT    = BASE_ADDR + OFS_CNT;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + OFS_STATUS;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {IDLE, READ} state_t;

    state_t      state_q, state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [7:0]  rid_q, rid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        sticky_q, sticky_d;
    logic [3:0]  beat_q, beat_d;
    logic [3:0]  len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic        bad_q, bad_d;
    logic        fixed_q, fixed_d;

    logic        handshake;
    logic        last_beat;
    logic        status_clr;
    logic [31:0] load_addr;
    logic        load_bad;
    logic [31:0] load_data;
    logic [1:0]  load_resp;

    // Address of the beat about to be loaded: the AR address when idle, else the next burst address.
    always_comb begin
        handshake  = rvalid_q & RREADY_S;
        last_beat  = (beat_q == len_q);
        status_clr = (state_q == READ) && handshake && !bad_q && (addr_q == ADDR_STATUS);
        if (state_q == IDLE) begin
            load_addr = ARADDR_S;
            load_bad  = (ARSIZE_S != 3'b010) || ARBURST_S[1];
        end else begin
            load_addr = fixed_q ? addr_q : addr_q + 32'd4;
            load_bad  = bad_q;
        end
    end

    always_comb begin
        load_data = 32'h0;
        load_resp = RESP_OKAY;
        if (load_bad) begin
            load_resp = RESP_SLVERR;
        end else if (load_addr == ADDR_WDEN) begin
            load_data = {31'b0, wden};
        end else if (load_addr == ADDR_WDLIVE) begin
            load_data = {31'b0, wdlive};
        end else if (load_addr == ADDR_WTOCNT) begin
            load_data = wtocnt;
        end else if (load_addr == ADDR_CNT) begin
            load_data = wdt_cnt;
        end else if (load_addr == ADDR_STATUS) begin
            load_data = {28'b0, wdlive, wden, sticky_q, wto};
        end else begin
            load_resp = RESP_SLVERR;
        end
    end

    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        beat_d    = beat_q;
        len_d     = len_q;
        addr_d    = addr_q;
        bad_d     = bad_q;
        fixed_d   = fixed_q;
        // A timeout in the same cycle as the clearing read keeps the flag set.
        sticky_d  = wto | (sticky_q & ~status_clr);
        case (state_q)
            IDLE: begin
                if (ARVALID_S) begin
                    state_d   = READ;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rid_d     = ARID_S;
                    len_d     = ARLEN_S;
                    beat_d    = 4'd0;
                    addr_d    = ARADDR_S;
                    bad_d     = load_bad;
                    fixed_d   = (ARBURST_S == 2'b00);
                    rdata_d   = load_data;
                    rresp_d   = load_resp;
                    rlast_d   = (ARLEN_S == 4'd0);
                end
            end
            READ: begin
                if (handshake) begin
                    if (last_beat) begin
                        state_d   = IDLE;
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        beat_d    = 4'd0;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        addr_d  = load_addr;
                        rdata_d = load_data;
                        rresp_d = load_resp;
                        rlast_d = ((beat_q + 4'd1) == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 8'h0;
            rdata_q   <= 32'h0;
            rresp_q   <= 2'b00;
            sticky_q  <= 1'b0;
            beat_q    <= 4'd0;
            len_q     <= 4'd0;
            addr_q    <= 32'h0;
            bad_q     <= 1'b0;
            fixed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            sticky_q  <= sticky_d;
            beat_q    <= beat_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            bad_q     <= bad_d;
            fixed_q   <= fixed_d;
        end
    end

    assign ARREADY_S = arready_q;
    assign RVALID_S  = rvalid_q;
    assign RLAST_S   = rlast_q;
    assign RID_S     = rid_q;
    assign RDATA_S   = rdata_q;
    assign RRESP_S   = rresp_q;

endmodule
